dev_loader_hex: RTL and testbench

- Parametrised successor to the byte-wise hex loader.
- Parses an ASCII hex stream from the UART receive path and writes it into RAM through if_dev_ram.
- Adds configurable store width (1/2/4/8 bytes per store), '@' address records, partial-word flush, RAM back-pressure, error reporting and a byte counter.
- Sits between the UART RX byte stream and the RAM arbiter during boot load.

---
 rtl/dev_loader_hex.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_dev_loader_hex.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dev_loader_hex.sv
// ASCII hex boot loader: turns a UART character stream into RAM stores of
// DATA_BYTES bytes, with '@' address records, partial-word flush and error reporting.

package pkg_ram;
   localparam int unsigned RAM_ADDRW = 16;
   localparam int unsigned RAM_QUADW = 64;
   localparam int unsigned RAM_SIZEW = 7;

   typedef logic [7:0]           RAM_BYTE;
   typedef logic [RAM_QUADW-1:0] RAM_QUAD;
   typedef logic [RAM_ADDRW-1:0] ram_addr_t;
   typedef logic [RAM_SIZEW-1:0] ram_size_t;
   typedef logic [1:0]           ram_op_t;

   localparam ram_op_t RAM_NOP   = 2'd0;
   localparam ram_op_t RAM_LOAD  = 2'd1;
   localparam ram_op_t RAM_STORE = 2'd2;

   // One RAM request as driven toward the arbiter
   typedef struct packed {
      ram_op_t   op;
      ram_addr_t addr;
      ram_size_t size;
      RAM_QUAD   data;
   } ram_req_t;
endpackage

interface if_dev_ram;
   pkg_ram::ram_op_t   op;
   pkg_ram::ram_addr_t addr;
   pkg_ram::ram_size_t size;
   pkg_ram::RAM_QUAD   data_in;

   modport master (output op, addr, size, data_in);
   modport slave  (input  op, addr, size, data_in);
endinterface

module dev_loader_hex #(
   parameter int unsigned DATA_BYTES = 1,
   parameter int unsigned START_ADDR = 0,
   parameter int unsigned CNT_W      = pkg_ram::RAM_ADDRW + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  pkg_ram::RAM_BYTE     data_in,
   input  logic                 data_en,
   output logic                 ready,
   input  logic                 ram_busy,
   if_dev_ram.master            ram,
   output logic                 done,
   output logic                 error,
   output logic [CNT_W-1:0]     byte_count
);
   import pkg_ram::*;

   localparam int unsigned AW     = RAM_ADDRW;
   localparam int unsigned QW     = RAM_QUADW;
   localparam int unsigned SW     = RAM_SIZEW;
   localparam int unsigned WORD_W = DATA_BYTES * 8;
   localparam int unsigned LANE_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam int unsigned CNT_XW = CNT_W + 1;

   localparam logic [AW-1:0]     ADDR_MASK = AW'(DATA_BYTES - 1);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(DATA_BYTES - 1);
   localparam ram_size_t         WORD_SIZE = SW'(DATA_BYTES * 8);

   localparam logic [1:0] S_DATA  = 2'd0;
   localparam logic [1:0] S_ADDR  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   logic [1:0]        state_q, state_n;
   logic [1:0]        flush_dst_q, flush_dst_n;
   logic              hi_q, hi_n;
   logic [3:0]        hi_nib_q, hi_nib_n;
   logic [LANE_W-1:0] k_q, k_n;
   logic [LANE_W-1:0] fidx_q, fidx_n;
   logic [WORD_W-1:0] word_q, word_n;
   logic [AW-1:0]     next_addr_q, next_addr_n;
   logic [AW-1:0]     addr_reg_q, addr_reg_n;
   logic              adig_q, adig_n;
   ram_req_t          req_q, req_n;
   logic [CNT_W-1:0]  cnt_q, cnt_n;
   logic              error_q, error_n;
   logic              done_q, done_n;
   logic              ready_q, ready_n;

   logic              is_hex, is_at, is_ws, is_term;
   logic [3:0]        nib;
   logic              accept, pend, issued, can_load, bad;
   logic [7:0]        byte_v, flush_byte;
   logic [CNT_XW-1:0] cnt_sum;

   // Character classification
   always_comb begin
      is_hex  = 1'b0;
      is_at   = 1'b0;
      is_ws   = 1'b0;
      is_term = 1'b0;
      nib     = 4'h0;
      if (data_in >= 8'h30 && data_in <= 8'h39) begin
         is_hex = 1'b1;
         nib    = 4'(data_in - 8'h30);
      end else if (data_in >= 8'h61 && data_in <= 8'h66) begin
         is_hex = 1'b1;
         nib    = 4'(data_in - 8'h57);
      end else if (data_in >= 8'h41 && data_in <= 8'h46) begin
         is_hex = 1'b1;
         nib    = 4'(data_in - 8'h37);
      end else if (data_in == 8'h40) begin
         is_at = 1'b1;
      end else if (data_in == 8'h20 || data_in == 8'h09) begin
         is_ws = 1'b1;
      end else if (data_in == 8'h0d || data_in == 8'h0a) begin
         is_term = 1'b1;
      end
   end

   assign accept   = data_en && ready_q;
   assign pend     = (req_q.op == RAM_STORE);
   assign issued   = pend && !ram_busy;
   assign can_load = !pend || !ram_busy;

   // Next-state and output logic
   always_comb begin
      state_n     = state_q;
      flush_dst_n = flush_dst_q;
      hi_n        = hi_q;
      hi_nib_n    = hi_nib_q;
      k_n         = k_q;
      fidx_n      = fidx_q;
      word_n      = word_q;
      next_addr_n = next_addr_q;
      addr_reg_n  = addr_reg_q;
      adig_n      = adig_q;
      req_n       = req_q;
      cnt_n       = cnt_q;
      error_n     = error_q;
      done_n      = done_q;
      ready_n     = ready_q;
      bad         = 1'b0;
      byte_v      = {hi_nib_q, nib};
      flush_byte  = 8'h00;
      cnt_sum     = '0;

      // Retire the presented store and account its bytes (saturating)
      if (issued) begin
         req_n.op = RAM_NOP;
         cnt_sum  = {1'b0, cnt_q} + CNT_XW'(req_q.size >> 3);
         cnt_n    = cnt_sum[CNT_XW-1] ? '1 : cnt_sum[CNT_W-1:0];
      end

      for (int i = 0; i < DATA_BYTES; i++) begin
         if (LANE_W'(i) == fidx_q) flush_byte = word_q[(DATA_BYTES-1-i)*8 +: 8];
      end

      case (state_q)
         S_DATA: begin
            if (accept) begin
               if (is_hex) begin
                  if (!hi_q) begin
                     hi_n     = 1'b1;
                     hi_nib_n = nib;
                  end else begin
                     hi_n = 1'b0;
                     for (int i = 0; i < DATA_BYTES; i++) begin
                        if (LANE_W'(i) == k_q) word_n[(DATA_BYTES-1-i)*8 +: 8] = byte_v;
                     end
                     if (k_q == LAST_LANE) begin
                        k_n          = '0;
                        req_n.op     = RAM_STORE;
                        req_n.addr   = next_addr_q;
                        req_n.size   = WORD_SIZE;
                        req_n.data   = QW'(word_n);
                        next_addr_n  = next_addr_q + AW'(DATA_BYTES);
                     end else begin
                        k_n = k_q + LANE_W'(1);
                     end
                  end
               end else if (is_ws) begin
                  bad = hi_q;
               end else if (is_at || is_term) begin
                  if (hi_q) begin
                     bad = 1'b1;
                  end else begin
                     addr_reg_n  = '0;
                     adig_n      = 1'b0;
                     fidx_n      = '0;
                     flush_dst_n = is_at ? S_ADDR : S_FIN;
                     if (k_q != '0) state_n = S_FLUSH;
                     else           state_n = is_at ? S_ADDR : S_FIN;
                  end
               end else begin
                  bad = 1'b1;
               end
            end
         end

         S_ADDR: begin
            if (accept) begin
               if (is_hex) begin
                  addr_reg_n = {addr_reg_q[AW-5:0], nib};
                  adig_n     = 1'b1;
               end else if (is_ws || is_term) begin
                  if (!adig_q || (addr_reg_q & ADDR_MASK) != '0) begin
                     bad = 1'b1;
                  end else begin
                     next_addr_n = addr_reg_q;
                     state_n     = is_ws ? S_DATA : S_FIN;
                  end
               end else begin
                  bad = 1'b1;
               end
            end
         end

         // Drain buffered lanes as single-byte stores at consecutive addresses
         S_FLUSH: begin
            if (can_load) begin
               req_n.op    = RAM_STORE;
               req_n.addr  = next_addr_q;
               req_n.size  = SW'(8);
               req_n.data  = QW'(flush_byte);
               next_addr_n = next_addr_q + AW'(1);
               if (fidx_q == k_q - LANE_W'(1)) begin
                  state_n = flush_dst_q;
                  k_n     = '0;
                  fidx_n  = '0;
               end else begin
                  fidx_n = fidx_q + LANE_W'(1);
               end
            end
         end

         default: ;
      endcase

      // Malformed input: stop, discard any partial word
      if (bad) begin
         error_n = 1'b1;
         state_n = S_FIN;
         k_n     = '0;
         hi_n    = 1'b0;
      end

      done_n  = done_q | error_n | ((state_n == S_FIN) && (req_n.op != RAM_STORE));
      ready_n = !done_n && ((state_n == S_DATA) || (state_n == S_ADDR)) &&
                (req_n.op != RAM_STORE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_DATA;
         flush_dst_q <= S_FIN;
         hi_q        <= 1'b0;
         hi_nib_q    <= 4'h0;
         k_q         <= '0;
         fidx_q      <= '0;
         word_q      <= '0;
         next_addr_q <= AW'(START_ADDR);
         addr_reg_q  <= '0;
         adig_q      <= 1'b0;
         req_q.op    <= RAM_NOP;
         req_q.addr  <= '0;
         req_q.size  <= WORD_SIZE;
         req_q.data  <= '0;
         cnt_q       <= '0;
         error_q     <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_n;
         flush_dst_q <= flush_dst_n;
         hi_q        <= hi_n;
         hi_nib_q    <= hi_nib_n;
         k_q         <= k_n;
         fidx_q      <= fidx_n;
         word_q      <= word_n;
         next_addr_q <= next_addr_n;
         addr_reg_q  <= addr_reg_n;
         adig_q      <= adig_n;
         req_q       <= req_n;
         cnt_q       <= cnt_n;
         error_q     <= error_n;
         done_q      <= done_n;
         ready_q     <= ready_n;
      end
   end

   assign ram.op      = req_q.op;
   assign ram.addr    = req_q.addr;
   assign ram.size    = req_q.size;
   assign ram.data_in = req_q.data;
   assign ready       = ready_q;
   assign done        = done_q;
   assign error       = error_q;
   assign byte_count  = cnt_q;

endmodule

// File: tb/tb_dev_loader_hex.sv
// Scoreboard bench for dev_loader_hex: three instances (1/2/4 bytes per store)
// share the character stream; a monitor checks the selected instance's stores.
module tb_dev_loader_hex;
   import pkg_ram::*;

   localparam int unsigned CW = RAM_ADDRW + 1;

   typedef struct {
      logic [15:0] addr;
      int          size;
      logic [63:0] data;
      int          cyc;
   } exp_t;

   logic    clk = 1'b0;
   logic    rst = 1'b1;
   RAM_BYTE data_in = 8'h00;
   logic    data_en = 1'b0;
   logic    ram_busy = 1'b0;

   logic          rdy1, rdy2, rdy4, done1, done2, done4, err1, err2, err4;
   logic [CW-1:0] cnt1, cnt2, cnt4;

   if_dev_ram ram1 ();
   if_dev_ram ram2 ();
   if_dev_ram ram4 ();

   dev_loader_hex #(.DATA_BYTES(1)) u_db1 (
      .clk(clk), .rst(rst), .data_in(data_in), .data_en(data_en), .ready(rdy1),
      .ram_busy(ram_busy), .ram(ram1), .done(done1), .error(err1), .byte_count(cnt1));
   dev_loader_hex #(.DATA_BYTES(2)) u_db2 (
      .clk(clk), .rst(rst), .data_in(data_in), .data_en(data_en), .ready(rdy2),
      .ram_busy(ram_busy), .ram(ram2), .done(done2), .error(err2), .byte_count(cnt2));
   dev_loader_hex #(.DATA_BYTES(4)) u_db4 (
      .clk(clk), .rst(rst), .data_in(data_in), .data_en(data_en), .ready(rdy4),
      .ram_busy(ram_busy), .ram(ram4), .done(done4), .error(err4), .byte_count(cnt4));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   sel = 1;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   logic          m_rdy, m_done, m_err;
   logic [CW-1:0] m_cnt;
   ram_op_t       m_op;
   ram_addr_t     m_addr;
   ram_size_t     m_size;
   RAM_QUAD       m_data;

   always_comb begin
      case (sel)
         2: begin
            m_rdy = rdy2; m_done = done2; m_err = err2; m_cnt = cnt2;
            m_op = ram2.op; m_addr = ram2.addr; m_size = ram2.size; m_data = ram2.data_in;
         end
         4: begin
            m_rdy = rdy4; m_done = done4; m_err = err4; m_cnt = cnt4;
            m_op = ram4.op; m_addr = ram4.addr; m_size = ram4.size; m_data = ram4.data_in;
         end
         default: begin
            m_rdy = rdy1; m_done = done1; m_err = err1; m_cnt = cnt1;
            m_op = ram1.op; m_addr = ram1.addr; m_size = ram1.size; m_data = ram1.data_in;
         end
      endcase
   end

   // Monitor: every accepted store must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && m_op == RAM_STORE && !ram_busy) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_store: got addr %0h size %0d data %0h at cycle %0d, required no store",
                     m_addr, m_size, m_data, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (m_addr !== mon_e.addr || m_size !== 7'(mon_e.size) || m_data !== mon_e.data ||
                (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
               errors++;
               $display("FAIL store: got addr %0h size %0d data %0h cycle %0d, required addr %0h size %0d data %0h cycle %0d",
                        m_addr, m_size, m_data, cyc, mon_e.addr, mon_e.size, mon_e.data, mon_e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] addr, input int size, input logic [63:0] data, input int c);
      exp_t e;
      e.addr = addr; e.size = size; e.data = data; e.cyc = c;
      exp_q.push_back(e);
   endtask

   // Present one character once ready; acc = cycle index in which it was consumed
   task automatic send(input RAM_BYTE c, output int acc);
      int n = 0;
      acc = -1;
      @(negedge clk);
      while (!m_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!m_rdy) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: char %0h ready %0b, required 1", c, m_rdy);
         return;
      end
      data_in = c;
      data_en = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      data_en = 1'b0;
   endtask

   task automatic send_str(input string s);
      int acc;
      for (int i = 0; i < s.len(); i++) send(s[i], acc);
   endtask

   task automatic do_reset(input int db);
      sel      = db;
      ram_busy = 1'b0;
      data_en  = 1'b0;
      rst      = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 64'(m_rdy), 64'd1);
      chk("rst_done",  64'(m_done), 64'd0);
      chk("rst_error", 64'(m_err), 64'd0);
      chk("rst_count", 64'(m_cnt), 64'd0);
      chk("rst_op",    64'(m_op), 64'(RAM_NOP));
      chk("rst_addr",  64'(m_addr), 64'd0);
      chk("rst_size",  64'(m_size), 64'(db * 8));
   endtask

   task automatic wait_done(input string name, input logic exp_err, input int exp_cnt);
      int n = 0;
      while (!m_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_done"}, 64'(m_done), 64'd1);
      chk({name, "_error"}, 64'(m_err), 64'(exp_err));
      chk({name, "_count"}, 64'(m_cnt), 64'(exp_cnt));
      chk({name, "_pending_stores"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int acc;

      // 1 byte/store, two stores one cycle after each low nibble
      do_reset(1);
      send(8'h30, acc); send(8'h61, acc); push(16'h0000, 8, 64'h0A, acc);
      send(8'h31, acc); send(8'h42, acc); push(16'h0001, 8, 64'h1B, acc);
      send(8'h0a, acc);
      wait_done("t1", 1'b0, 2);

      // 4 bytes/store with a one-byte tail flushed on the terminator
      do_reset(4);
      send_str("DEADBEE"); send(8'h46, acc); push(16'h0000, 32, 64'hDEADBEEF, acc);
      send_str(" 01");
      send(8'h0a, acc); push(16'h0004, 8, 64'h01, -1);
      wait_done("t2", 1'b0, 5);

      // '@' record relocates the first word
      do_reset(4);
      send_str("@100 1122334"); send(8'h34, acc); push(16'h0100, 32, 64'h11223344, acc);
      send(8'h0a, acc);
      wait_done("t3", 1'b0, 4);

      // misaligned address record
      do_reset(4);
      send_str("@102"); send(8'h20, acc);
      chk("t4_error_next", 64'(m_err), 64'd1);
      chk("t4_done_next", 64'(m_done), 64'd1);
      wait_done("t4", 1'b1, 0);

      // RAM back-pressure: request held for 3 busy cycles, then one store
      do_reset(2);
      send_str("A5C"); send(8'h33, acc);
      ram_busy = 1'b1;
      push(16'h0000, 16, 64'hA5C3, acc + 3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_ready_busy", 64'(m_rdy), 64'd0);
         chk("t5_op_held", 64'(m_op), 64'(RAM_STORE));
         chk("t5_data_held", m_data, 64'hA5C3);
      end
      @(posedge clk);
      #1 ram_busy = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_count", 64'(m_cnt), 64'd2);
      chk("t5_not_done", 64'(m_done), 64'd0);
      chk("t5_pending_stores", 64'(exp_q.size()), 64'd0);

      // whitespace between nibbles
      do_reset(1);
      send(8'h31, acc); send(8'h20, acc);
      chk("t6_error_next", 64'(m_err), 64'd1);
      wait_done("t6", 1'b1, 0);

      // illegal character after a completed byte
      do_reset(1);
      send(8'h34, acc); send(8'h35, acc); push(16'h0000, 8, 64'h45, acc);
      send(8'h78, acc);
      wait_done("t7", 1'b1, 1);

      // reset while a store is held by back-pressure
      do_reset(1);
      send(8'h31, acc); send(8'h31, acc); push(16'h0000, 8, 64'h11, acc);
      repeat (2) @(negedge clk);
      ram_busy = 1'b1;
      send(8'h32, acc); send(8'h32, acc);
      @(negedge clk);
      chk("t8_op_pending", 64'(m_op), 64'(RAM_STORE));
      chk("t8_count_before", 64'(m_cnt), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t8_op_after_rst", 64'(m_op), 64'(RAM_NOP));
      chk("t8_count_after_rst", 64'(m_cnt), 64'd0);
      chk("t8_addr_after_rst", 64'(m_addr), 64'd0);
      rst = 1'b0;
      ram_busy = 1'b0;
      send(8'h37, acc); send(8'h37, acc); push(16'h0000, 8, 64'h77, acc);
      send(8'h0a, acc);
      wait_done("t8", 1'b0, 1);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
